std_skid_slice: RTL and testbench

//  - Two-entry valid/ready register slice (skid buffer) that cuts timing on both the forward
//    (valid/data) path and the backward (ready) path.
//  - Sits between a producer stage and the next pipeline stage of the NoC datapath.
//  - Full throughput: 1 beat/cycle. Latency: 1 cycle. No combinational in->out path.
//  - Data registers load a per-bit reset value, so downstream never sees X after reset.

---
 rtl/std_skid_pkg.sv | 5 +
 rtl/std_dffre_sync.sv | 16 +
 rtl/std_skid_slice.sv | 79 +++++++
 tb/tb_std_skid_slice.sv | 136 +++++++++++++
 4 files changed

// File: rtl/std_skid_pkg.sv
// std_skid_pkg: state encoding shared by the skid slice
package std_skid_pkg;
    localparam int StateW = 2;
    typedef enum logic [StateW-1:0] {EMPTY, BUSY, FULL} skid_state_e;
endpackage

// File: rtl/std_dffre_sync.sv
// std_dffre_sync: enable flop with synchronous active-low reset to DRST
module std_dffre_sync #(
    parameter int             W    = 8,
    parameter logic [W-1:0]   DRST = '0
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge CLK) begin
        if (!RSTN) q <= DRST;
        else if (en) q <= d;
    end
endmodule

// File: rtl/std_skid_slice.sv
// std_skid_slice: two-entry valid/ready skid buffer; STD_SKID_PERF_CNT_EN enables the stall counter
module std_skid_slice
    import std_skid_pkg::*;
#(
    parameter int               Width   = 8,
    parameter logic [Width-1:0] DataRst = '0,
    parameter int               CntW    = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data,
    output logic [CntW-1:0]  perf_stall_cnt
);
    skid_state_e      state_q, state_d;
    logic             out_valid_q, in_ready_q;
    logic             in_fire, out_fire;
    logic             main_en, skid_en, main_from_skid;
    logic [Width-1:0] main_d, skid_q;
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                state_d = in_fire ? BUSY : EMPTY;
                main_en = in_fire;
            end
            BUSY: begin
                state_d = (in_fire & !out_ready) ? FULL : (!in_fire & out_fire) ? EMPTY : BUSY;
                main_en = in_fire & out_fire;
                skid_en = in_fire & !out_ready;
            end
            default: begin
                state_d        = out_fire ? BUSY : FULL;
                main_en        = out_fire;
                main_from_skid = 1'b1;
            end
        endcase
    end
    assign main_d = main_from_skid ? skid_q : in_data;
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != FULL);
        end
    end
    std_dffre_sync #(.W(Width), .DRST(DataRst)) u_main (
        .CLK(CLK), .RSTN(RSTN), .en(main_en), .d(main_d), .q(out_data)
    );
    std_dffre_sync #(.W(Width), .DRST(DataRst)) u_skid (
        .CLK(CLK), .RSTN(RSTN), .en(skid_en), .d(in_data), .q(skid_q)
    );
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
`ifdef STD_SKID_PERF_CNT_EN
    logic [CntW-1:0] cnt_q, cnt_d;
    assign cnt_d = (out_valid_q & !out_ready & (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge CLK) begin
        if (!RSTN) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign perf_stall_cnt = cnt_q;
`else
    assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_std_skid_slice.sv
// tb_std_skid_slice: directed and random checks of the skid slice
module tb_std_skid_slice;
    logic       clk = 1'b0;
    logic       rstn, in_valid, out_ready, in_ready, out_valid;
    logic [7:0] in_data, out_data;
    logic [3:0] perf;
    int         vectors = 0, fails = 0;
    logic [7:0] q[$];
    logic [7:0] held, exp_b;
    logic       stalled;

    std_skid_slice #(.Width(8), .DataRst(8'hA5), .CntW(4)) dut (
        .CLK(clk), .RSTN(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .perf_stall_cnt(perf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 8'hA5);
        chk("rst_perf", perf, 0);
        rstn = 1'b1;

        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_data", out_data, i);
            chk("stream_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain", out_valid, 0);

        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        tick();
        chk("stall_busy_data", out_data, 8'h11);
        chk("stall_busy_ready", in_ready, 1);
        in_data = 8'h22;
        tick();
        chk("stall_full_ready", in_ready, 0);
        chk("stall_full_data", out_data, 8'h11);
        in_data = 8'h33;
        tick();
        chk("stall_ignore_data", out_data, 8'h11);
        chk("stall_ignore_ready", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("release_data", out_data, 8'h22);
        chk("release_valid", out_valid, 1);
        chk("release_ready", in_ready, 1);
        tick();
        chk("release_empty", out_valid, 0);
        chk("release_no_dup", out_data, 8'h22);

        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h66;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
`ifdef STD_SKID_PERF_CNT_EN
        chk("perf_saturate", perf, 15);
`else
        chk("perf_off", perf, 0);
`endif
        chk("perf_hold_data", out_data, 8'h66);

        in_valid = 1'b1; in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        chk("midrst_full", in_ready, 0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_data", out_data, 8'hA5);
        chk("midrst_perf", perf, 0);
        out_ready = 1'b1;
        tick();
        chk("midrst_dropped", out_valid, 0);

        stalled = 1'b0; held = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            if (stalled) begin
                chk("rand_stable_valid", out_valid, 1);
                chk("rand_stable_data", out_data, held);
            end
            chk("rand_occ_valid", out_valid, q.size() > 0);
            chk("rand_occ_ready", in_ready, q.size() < 2);
            if (out_valid && out_ready && q.size() > 0) begin
                exp_b = q.pop_front();
                chk("rand_order", out_data, exp_b);
            end
            if (in_valid && in_ready) q.push_back(in_data);
            stalled = out_valid & ~out_ready;
            held = out_data;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            if (out_valid && q.size() > 0) begin
                exp_b = q.pop_front();
                chk("drain_order", out_data, exp_b);
            end
            tick();
        end
        chk("drain_queue_empty", q.size(), 0);
        chk("drain_out_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
